// File: rtl/ring_step_ctrl_if.sv
// Signal bundle between the board push-button pin and the ring counter's
// step/direction inputs. The controller sits on the slave side.
interface ring_step_ctrl_if;
    logic sw_i;    // raw switch, asynchronous, 1 = pressed
    logic step_o;  // one-cycle advance pulse for the ring counter
    logic dir_o;   // 0 = forward, 1 = reverse
    logic auto_o;  // 0 = manual, 1 = auto stepping

    // Board / stimulus side: drives the switch, observes the ring controls.
    modport master (
        output sw_i,
        input  step_o,
        input  dir_o,
        input  auto_o
    );

    // Controller side.
    modport slave (
        input  sw_i,
        output step_o,
        output dir_o,
        output auto_o
    );
endinterface

// File: rtl/ring_step_ctrl.sv
// Push-button sequencer for the 4-LED ring counter: synchronises and
// debounces the switch, classifies presses as short or long, and issues
// step pulses plus direction/mode flags in manual or auto mode.
module ring_step_ctrl #(
    parameter int DEBOUNCE_LIMIT = 250000,   // cycles a new level must persist
    parameter int LONG_PRESS     = 25000000, // cycles of hold for a long press
    parameter int AUTO_PERIOD    = 2500000   // cycles between auto steps
) (
    input  logic            clk_i,
    input  logic            rst_i,
    ring_step_ctrl_if.slave bus
);

    localparam int DB_W   = $clog2(DEBOUNCE_LIMIT);
    localparam int HOLD_W = $clog2(LONG_PRESS);
    localparam int TMR_W  = $clog2(AUTO_PERIOD);

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_LIMIT - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS - 1);
    localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(AUTO_PERIOD - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HELD = 2'd1,
        LONG = 2'd2
    } press_state_t;

    logic              sync_ff1;
    logic              sync_q;
    logic              stable_q;
    logic [DB_W-1:0]   db_cnt;
    press_state_t      state_q;
    logic [HOLD_W-1:0] hold_cnt;
    logic [TMR_W-1:0]  tmr;
    logic              step_q;
    logic              dir_q;
    logic              auto_q;
    logic              dir_pend;

    logic              short_evt;
    logic              long_evt;
    logic              tmr_wrap;

    // Two-flop synchroniser bringing the asynchronous switch into clk_i.
    // NOTE: sequential state always uses <= so every flop samples the
    // pre-edge value of the others; with = the second stage would copy the
    // new first-stage value and the synchroniser would collapse to one flop.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_ff1 <= 1'b0;
            sync_q   <= 1'b0;
        end else begin
            sync_ff1 <= bus.sw_i;
            sync_q   <= sync_ff1;
        end
    end

    // Debouncer: accept a new level only after it has persisted for
    // DEBOUNCE_LIMIT consecutive cycles; any bounce back restarts the count.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stable_q <= 1'b0;
            db_cnt   <= '0;
        end else if (sync_q == stable_q) begin
            db_cnt <= '0;
        end else if (db_cnt == DB_LAST) begin
            stable_q <= sync_q;
            db_cnt   <= '0;
        end else begin
            db_cnt <= db_cnt + 1'b1;
        end
    end

    // Press events decoded from the FSM state; they take effect on the
    // output registers at the next edge.
    // NOTE: every signal driven here gets a default before any condition,
    // so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        short_evt = 1'b0;
        long_evt  = 1'b0;
        if (state_q == HELD) begin
            short_evt = !stable_q;
            long_evt  = stable_q && (hold_cnt == HOLD_LAST);
        end
    end

    // Press classifier: time how long the debounced switch stays down.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            hold_cnt <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (stable_q) begin
                        state_q  <= HELD;
                        hold_cnt <= '0;
                    end
                end
                HELD: begin
                    if (!stable_q) begin
                        state_q <= IDLE;
                    end else if (hold_cnt == HOLD_LAST) begin
                        state_q <= LONG;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                LONG: begin
                    if (!stable_q) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // The auto timer is about to wrap; only meaningful while in auto mode.
    assign tmr_wrap = auto_q && (tmr == TMR_LAST);

    // Output stage: mode toggling, auto timer, step pulses and direction.
    // A short press that lands on an auto step defers the direction flip by
    // one cycle so the ring consumes that step with the old direction.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            step_q   <= 1'b0;
            dir_q    <= 1'b0;
            auto_q   <= 1'b0;
            dir_pend <= 1'b0;
            tmr      <= '0;
        end else begin
            step_q <= 1'b0;

            if (long_evt) begin
                // Mode change wins over a coincident wrap: no step on exit.
                auto_q <= !auto_q;
                tmr    <= '0;
            end else if (auto_q) begin
                if (tmr_wrap) begin
                    tmr    <= '0;
                    step_q <= 1'b1;
                end else begin
                    tmr <= tmr + 1'b1;
                end
            end else begin
                tmr <= '0;
            end

            if (short_evt && !auto_q) begin
                step_q <= 1'b1;
            end

            dir_pend <= short_evt && auto_q && tmr_wrap;
            if (dir_pend || (short_evt && auto_q && !tmr_wrap)) begin
                dir_q <= !dir_q;
            end
        end
    end

    assign bus.step_o = step_q;
    assign bus.dir_o  = dir_q;
    assign bus.auto_o = auto_q;

endmodule
